// File: rtl/div_p4.sv
// Final FP32 divide stage: normalizes the div_p3 quotient, applies overflow/underflow/zero rules
// and packs the result. Optional status flags when DIV_P4_FLAGS_EN is defined.
module div_p4 #(
  parameter int unsigned BIAS   = 127,
  parameter int unsigned MANT_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sign_in,
  input  logic [8:0]        exp_in,
  input  logic [MANT_W-1:0] mant_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       result
`ifdef DIV_P4_FLAGS_EN
  ,
  output logic              flag_ovf,
  output logic              flag_unf,
  output logic              flag_zero,
  output logic [2:0]        flag_sticky,
  input  logic              flag_clr
`endif
);

  localparam int unsigned LzW = $clog2(MANT_W + 1);
  localparam logic signed [9:0] ExpOvf = 10'(2 * BIAS + 1);

  // Handshake
  logic s1_valid_q;
  logic s2_valid_q;
  logic s1_adv;
  logic s2_adv;
  logic accept;

  assign s2_adv    = !s2_valid_q || out_ready;
  assign s1_adv    = s2_adv;
  assign in_ready  = !s1_valid_q || s1_adv;
  assign accept    = in_valid && in_ready;
  assign out_valid = s2_valid_q;

  // Stage 1: leading-zero count and normalization
  logic [LzW-1:0]      lzc;
  logic [MANT_W-2:0]   frac_n;
  logic signed [9:0]   e1;

  always_comb begin
    lzc = LzW'(MANT_W);
    // Ascending scan: the highest set bit is the last to write
    for (int i = 0; i < int'(MANT_W); i++) begin
      if (mant_in[i]) begin
        lzc = LzW'(int'(MANT_W) - 1 - i);
      end
    end
  end

  assign frac_n = (MANT_W - 1)'(mant_in << lzc);
  assign e1     = $signed({1'b0, exp_in}) - $signed({{(10 - LzW){1'b0}}, lzc});

  logic                s1_sign_q;
  logic signed [9:0]   s1_exp_q;
  logic [MANT_W-2:0]   s1_frac_q;
  logic                s1_zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_frac_q  <= '0;
      s1_zero_q  <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid_q <= in_valid;
      end
      if (accept) begin
        s1_sign_q <= sign_in;
        s1_exp_q  <= e1;
        s1_frac_q <= frac_n;
        s1_zero_q <= (mant_in == '0);
      end
    end
  end

  // Stage 2: exception classification and packing
  logic        zero_c;
  logic        ovf_c;
  logic        unf_c;
  logic [31:0] s2_result_d;
  logic [31:0] s2_result_q;

  always_comb begin
    zero_c      = 1'b0;
    ovf_c       = 1'b0;
    unf_c       = 1'b0;
    s2_result_d = {s1_sign_q, 31'b0};
    if (s1_zero_q) begin
      zero_c = 1'b1;
    end else if (s1_exp_q >= ExpOvf) begin
      ovf_c       = 1'b1;
      s2_result_d = {s1_sign_q, 8'hFF, 23'b0};
    end else if (s1_exp_q <= 10'sd0) begin
      unf_c = 1'b1;
    end else begin
      s2_result_d = {s1_sign_q, s1_exp_q[7:0], s1_frac_q[MANT_W-2 -: 23]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_result_q <= s2_result_d;
      end
    end
  end

  assign result = s2_result_q;

`ifdef DIV_P4_FLAGS_EN
  logic       ovf_q;
  logic       unf_q;
  logic       zero_q;
  logic [2:0] sticky_q;
  logic [2:0] sticky_d;

  always_comb begin
    sticky_d = sticky_q;
    if (flag_clr) begin
      sticky_d = 3'b000;
    end else if (s2_valid_q && out_ready) begin
      sticky_d = sticky_q | {ovf_q, unf_q, zero_q};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      zero_q   <= 1'b0;
      sticky_q <= 3'b000;
    end else begin
      sticky_q <= sticky_d;
      if (s2_adv && s1_valid_q) begin
        ovf_q  <= ovf_c;
        unf_q  <= unf_c;
        zero_q <= zero_c;
      end
    end
  end

  assign flag_ovf    = ovf_q;
  assign flag_unf    = unf_q;
  assign flag_zero   = zero_q;
  assign flag_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_div_p4.sv
// Randomized self-checking bench for div_p4 against an arithmetic reference model and queue.
module tb_div_p4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic [8:0]  exp_in;
  logic [23:0] mant_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
`ifdef DIV_P4_FLAGS_EN
  logic        flag_ovf;
  logic        flag_unf;
  logic        flag_zero;
  logic [2:0]  flag_sticky;
  logic        flag_clr;
  logic [2:0]  sticky_m;
`endif

  always #5 clk = ~clk;

  div_p4 #(.BIAS(127), .MANT_W(24)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sign_in    (sign_in),
    .exp_in     (exp_in),
    .mant_in    (mant_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result)
`ifdef DIV_P4_FLAGS_EN
    ,
    .flag_ovf   (flag_ovf),
    .flag_unf   (flag_unf),
    .flag_zero  (flag_zero),
    .flag_sticky(flag_sticky),
    .flag_clr   (flag_clr)
`endif
  );

  typedef struct {
    logic [31:0] res;
    logic [2:0]  fl;   // {ovf, unf, zero}
    int          acc;  // edge count at which the input was accepted
  } ent_t;

  ent_t q[$];
  int   cyc;
  int   checks;
  int   errors;

  // Reference: normalize by repeated doubling, then apply exception limits
  function automatic logic [34:0] ref_pack(logic s, int e, int m);
    int sh;
    int e1;
    logic [31:0] r;
    sh = 0;
    if (m == 0) return {3'b001, s, 31'b0};
    while (m < 'h800000) begin
      m = m * 2;
      sh++;
    end
    e1 = e - sh;
    if (e1 >= 255) return {3'b100, s, 8'hFF, 23'b0};
    if (e1 <= 0) return {3'b010, s, 31'b0};
    r = {s, e1[7:0], m[22:0]};
    return {3'b000, r};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit model_in_ready();
    return !(q.size() == 2 && !out_ready);
  endfunction

  function automatic bit model_out_valid();
    return q.size() > 0 && cyc >= q[0].acc + 1;
  endfunction

  // One clock: update model on the edge, then compare DUT outputs 1 time unit later
  task automatic tick();
    bit exp_ir;
    bit exp_ov;
    logic [34:0] p;
    ent_t e;
    exp_ir = model_in_ready();
    exp_ov = model_out_valid();
    @(posedge clk);
    cyc++;
    if (exp_ov && out_ready) begin
`ifdef DIV_P4_FLAGS_EN
      sticky_m = sticky_m | q[0].fl;
`endif
      void'(q.pop_front());
    end
`ifdef DIV_P4_FLAGS_EN
    if (flag_clr) sticky_m = 3'b000;
`endif
    if (in_valid && exp_ir) begin
      p     = ref_pack(sign_in, int'(exp_in), int'(mant_in));
      e.res = p[31:0];
      e.fl  = p[34:32];
      e.acc = cyc;
      q.push_back(e);
    end
    #1;
    chk("in_ready", {31'b0, in_ready}, {31'b0, model_in_ready()});
    chk("out_valid", {31'b0, out_valid}, {31'b0, model_out_valid()});
    if (model_out_valid()) begin
      chk("result", result, q[0].res);
`ifdef DIV_P4_FLAGS_EN
      chk("flags", {29'b0, flag_ovf, flag_unf, flag_zero}, {29'b0, q[0].fl});
`endif
    end
`ifdef DIV_P4_FLAGS_EN
    chk("sticky", {29'b0, flag_sticky}, {29'b0, sticky_m});
`endif
  endtask

  task automatic drive(input logic v, input logic s, input logic [8:0] e, input logic [23:0] m);
    in_valid = v;
    sign_in  = s;
    exp_in   = e;
    mant_in  = m;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++) tick();
    if (q.size() > 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic directed(input string name, input logic s, input logic [8:0] e,
                          input logic [23:0] m, input logic [31:0] exp_res,
                          input logic [2:0] exp_fl);
    out_ready = 1'b1;
    drive(1'b1, s, e, m);
    tick();
    drive(1'b0, 1'b0, 9'd0, 24'd0);
    tick();
    chk({name, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk(name, result, exp_res);
`ifdef DIV_P4_FLAGS_EN
    chk({name, "_flags"}, {29'b0, flag_ovf, flag_unf, flag_zero}, {29'b0, exp_fl});
`else
    if (exp_fl == 3'b111) chk("unused", 32'd0, 32'd0);
`endif
    tick();
  endtask

  task automatic check_reset_state(input string name);
    chk({name, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    chk({name, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    chk({name, "_result"}, result, 32'd0);
`ifdef DIV_P4_FLAGS_EN
    chk({name, "_flags"}, {28'b0, flag_ovf, flag_unf, flag_zero, 1'b0}, 32'd0);
    chk({name, "_sticky"}, {29'b0, flag_sticky}, 32'd0);
`endif
  endtask

  logic [34:0] p;
  logic [31:0] held;
  int          sent;
  int          e_r;
  int          m_r;
  bit          acc;

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 1'b0, 9'd0, 24'd0);
`ifdef DIV_P4_FLAGS_EN
    flag_clr = 1'b0;
    sticky_m = 3'b000;
`endif

    // Pin the reference model with hand-computed values
    p = ref_pack(1'b0, 127, 'h800000);
    chk("model_one", p[31:0], 32'h3F80_0000);
    p = ref_pack(1'b1, 128, 'h400000);
    chk("model_neg_one", p[31:0], 32'hBF80_0000);
    p = ref_pack(1'b0, 300, 'hC00000);
    chk("model_ovf", {p[34:32], p[31:0]} == {3'b100, 32'h7F80_0000} ? 32'd1 : 32'd0, 32'd1);
    p = ref_pack(1'b1, 20, 'h000001);
    chk("model_unf", {p[34:32], p[31:0]} == {3'b010, 32'h8000_0000} ? 32'd1 : 32'd0, 32'd1);
    p = ref_pack(1'b0, 127, 0);
    chk("model_zero", {p[34:32], p[31:0]} == {3'b001, 32'h0} ? 32'd1 : 32'd0, 32'd1);

    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    directed("dir_one", 1'b0, 9'd127, 24'h800000, 32'h3F80_0000, 3'b000);
    directed("dir_lzc1", 1'b1, 9'd128, 24'h400000, 32'hBF80_0000, 3'b000);
    directed("dir_ovf", 1'b0, 9'd300, 24'hC00000, 32'h7F80_0000, 3'b100);
    directed("dir_unf", 1'b1, 9'd20, 24'h000001, 32'h8000_0000, 3'b010);
    directed("dir_zero", 1'b0, 9'd127, 24'h000000, 32'h0000_0000, 3'b001);
    directed("dir_e254", 1'b0, 9'd254, 24'hFFFFFF, 32'h7F7F_FFFF, 3'b000);
    directed("dir_e1", 1'b1, 9'd1, 24'h800001, 32'h8080_0001, 3'b000);

    // Four back-to-back inputs into a stalled consumer
    out_ready = 1'b0;
    sent      = 0;
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, sent[0], 9'(100 + sent), 24'(32'h800000 | sent));
      acc = in_valid && in_ready;
      tick();
      if (acc) sent++;
      if (c == 1) held = result;
    end
    chk("stall_accepts", sent, 2);
    chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
    chk("stall_hold", result, held);
    out_ready = 1'b1;
    while (sent < 4) begin
      drive(1'b1, sent[0], 9'(100 + sent), 24'(32'h800000 | sent));
      acc = in_valid && in_ready;
      tick();
      if (acc) sent++;
    end
    drain();

    // Randomized traffic with boundary-heavy exponents and varied leading-zero counts
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 3))
        0:       e_r = $urandom_range(0, 30);
        1:       e_r = $urandom_range(240, 280);
        default: e_r = $urandom_range(0, 511);
      endcase
      m_r = int'(($urandom & 32'h00FF_FFFF) >> $urandom_range(0, 24));
      drive(($urandom % 4) != 0, 1'($urandom), 9'(e_r), 24'(m_r));
      out_ready = ($urandom % 3) != 0;
`ifdef DIV_P4_FLAGS_EN
      flag_clr = ($urandom % 16) == 0;
`endif
      tick();
    end
`ifdef DIV_P4_FLAGS_EN
    flag_clr = 1'b0;
`endif
    drain();

`ifdef DIV_P4_FLAGS_EN
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    directed("st_ovf", 1'b0, 9'd300, 24'hC00000, 32'h7F80_0000, 3'b100);
    directed("st_unf", 1'b1, 9'd20, 24'h000001, 32'h8000_0000, 3'b010);
    directed("st_zero", 1'b0, 9'd127, 24'h000000, 32'h0000_0000, 3'b001);
    drain();
    chk("sticky_all", {29'b0, flag_sticky}, 32'd7);
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    chk("sticky_clr", {29'b0, flag_sticky}, 32'd0);
`endif

    // Fill both stages, then reset asynchronously between edges
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b0, 9'd127, 24'h800000);
      tick();
    end
    chk("full_out_valid", {31'b0, out_valid}, 32'd1);
    chk("full_in_ready", {31'b0, in_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("async_reset");
    q.delete();
`ifdef DIV_P4_FLAGS_EN
    sticky_m = 3'b000;
`endif
    @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 9'd128, 24'h400000);
    tick();
    drive(1'b0, 1'b0, 9'd0, 24'd0);
    tick();
    chk("post_reset_result", result, 32'hBF80_0000);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
